// File: rtl/aes_blk_seq.sv
// AES block sequencer: streams 16-byte blocks from the source word SRAM through the
// AES-128 core and writes each result block back to the destination word SRAM.
module aes_blk_seq #(
    parameter int ADDR_W = 9
) (
    input  logic              iClk,
    input  logic              iRsn,
    input  logic              iStart,
    input  logic              iAbort,
    input  logic [15:0]       iByteSize,
    output logic              oBusy,
    output logic              oDone,
    output logic              oSrcCs,
    output logic [ADDR_W-1:0] oSrcAddr,
    input  logic [31:0]       iSrcRdata,
    output logic              oAesStart,
    output logic [127:0]      oAesDin,
    input  logic              iAesDone,
    input  logic [127:0]      iAesDout,
    output logic              oDstCs,
    output logic              oDstWe,
    output logic [ADDR_W-1:0] oDstAddr,
    output logic [31:0]       oDstWdata,
    output logic [2:0]        oDbgState
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_REQ,
        S_WAIT,
        S_WR,
        S_NEXT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [16:0]         r_nblk;
    logic [16:0]         r_blk;
    logic [2:0]          r_word;
    logic                r_busy;
    logic                r_done;
    logic                r_src_cs;
    logic [ADDR_W-1:0]   r_src_addr;
    logic                r_aes_start;
    logic [127:0]        r_din;
    logic [127:0]        r_dout;
    logic                r_dst_cs;
    logic                r_dst_we;
    logic [ADDR_W-1:0]   r_dst_addr;
    logic [31:0]         r_dst_wdata;

    logic [16:0]         w_nblk;
    logic [16:0]         w_blk_next;
    logic [ADDR_W-1:0]   w_base;
    logic [ADDR_W-1:0]   w_next_base;
    logic [1:0]          w_rd_slot;
    logic [1:0]          w_wr_slot;

    // Word w of a block lives in state bits [(3-w)*32 +: 32]; ~w gives that slot.
    assign w_nblk      = ({1'b0, iByteSize} + 17'd15) >> 4;
    assign w_blk_next  = r_blk + 17'd1;
    assign w_base      = {r_blk[ADDR_W-3:0], 2'b00};
    assign w_next_base = {w_blk_next[ADDR_W-3:0], 2'b00};
    assign w_rd_slot   = ~(r_word[1:0] - 2'd1);
    assign w_wr_slot   = ~(r_word[1:0] + 2'd1);

    function automatic logic [31:0] f_bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    always_ff @(posedge iClk) begin
        if (!iRsn) begin
            r_state     <= S_IDLE;
            r_nblk      <= '0;
            r_blk       <= '0;
            r_word      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_src_cs    <= 1'b0;
            r_src_addr  <= '0;
            r_aes_start <= 1'b0;
            r_din       <= '0;
            r_dout      <= '0;
            r_dst_cs    <= 1'b0;
            r_dst_we    <= 1'b0;
            r_dst_addr  <= '0;
            r_dst_wdata <= '0;
        end else begin
            r_done      <= 1'b0;
            r_aes_start <= 1'b0;
            if (iAbort) begin
                // Abort beats a simultaneous start and cuts any transfer in flight.
                r_state  <= S_IDLE;
                r_busy   <= 1'b0;
                r_src_cs <= 1'b0;
                r_dst_cs <= 1'b0;
                r_dst_we <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (iStart) begin
                            r_nblk <= w_nblk;
                            r_blk  <= '0;
                            r_word <= '0;
                            if (w_nblk == 17'd0) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state    <= S_RD;
                                r_busy     <= 1'b1;
                                r_src_cs   <= 1'b1;
                                r_src_addr <= '0;
                            end
                        end
                    end
                    S_RD: begin
                        // Reads issue in cycles 0..3, data arrives one cycle later.
                        r_word <= r_word + 3'd1;
                        if (r_word != 3'd0) begin
                            r_din[{w_rd_slot, 5'd0} +: 32] <= f_bswap(iSrcRdata);
                        end
                        if (r_word < 3'd3) begin
                            r_src_addr <= r_src_addr + ADDR_W'(1);
                        end
                        if (r_word == 3'd3) begin
                            r_src_cs <= 1'b0;
                        end
                        if (r_word == 3'd4) begin
                            r_state     <= S_REQ;
                            r_aes_start <= 1'b1;
                        end
                    end
                    S_REQ: begin
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (iAesDone) begin
                            r_dout      <= iAesDout;
                            r_dst_cs    <= 1'b1;
                            r_dst_we    <= 1'b1;
                            r_dst_addr  <= w_base;
                            r_dst_wdata <= f_bswap(iAesDout[127:96]);
                            r_word      <= '0;
                            r_state     <= S_WR;
                        end
                    end
                    S_WR: begin
                        r_word <= r_word + 3'd1;
                        if (r_word == 3'd3) begin
                            r_dst_cs <= 1'b0;
                            r_dst_we <= 1'b0;
                            r_state  <= S_NEXT;
                        end else begin
                            r_dst_addr  <= r_dst_addr + ADDR_W'(1);
                            r_dst_wdata <= f_bswap(r_dout[{w_wr_slot, 5'd0} +: 32]);
                        end
                    end
                    S_NEXT: begin
                        r_blk  <= w_blk_next;
                        r_word <= '0;
                        if (w_blk_next == r_nblk) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= S_RD;
                            r_src_cs   <= 1'b1;
                            r_src_addr <= w_next_base;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign oBusy     = r_busy;
    assign oDone     = r_done;
    assign oSrcCs    = r_src_cs;
    assign oSrcAddr  = r_src_addr;
    assign oAesStart = r_aes_start;
    assign oAesDin   = r_din;
    assign oDstCs    = r_dst_cs;
    assign oDstWe    = r_dst_we;
    assign oDstAddr  = r_dst_addr;
    assign oDstWdata = r_dst_wdata;
    assign oDbgState = r_state;

endmodule
